// File: rtl/fifo_registers_pkg.sv
// Shared helpers for the flip-flop FIFO.
package fifo_registers_pkg;

    // Advance a circular index. DEPTH need not be a power of two, so the
    // wrap is an explicit compare, not a truncating add.
    function automatic int unsigned wrap_inc(input int unsigned idx,
                                             input int unsigned depth);
        if (idx >= depth - 1)
            return 0;
        else
            return idx + 1;
    endfunction

endpackage

// File: rtl/fifo_registers.sv
// Single-clock FIFO built from flip-flops, with registered read data and
// full / empty / almost-full / almost-empty flags decoded from the count.
module fifo_registers
    import fifo_registers_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 2,
    parameter int AE_LEVEL = 2
) (
    input  logic             i_Clk,
    input  logic             i_Rst_Sync,
    input  logic             i_Wr_En,
    input  logic [WIDTH-1:0] i_Wr_Data,
    output logic             o_AF,
    output logic             o_Full,
    input  logic             i_Rd_En,
    output logic [WIDTH-1:0] o_Rd_Data,
    output logic             o_AE,
    output logic             o_Empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [CNT_W-1:0] count;
    logic             wr_ok;
    logic             rd_ok;

    // Acceptance uses the registered flags, so a write into a full FIFO or a
    // read from an empty one never disturbs state, and empty wr+rd never
    // falls through.
    assign wr_ok = i_Wr_En & ~o_Full;
    assign rd_ok = i_Rd_En & ~o_Empty;

    assign o_Full  = (count == CNT_W'(DEPTH));
    assign o_Empty = (count == '0);
    assign o_AF    = (count >= CNT_W'(AF_LEVEL));
    assign o_AE    = (count <= CNT_W'(AE_LEVEL));

    // Storage write; contents are don't-care after reset so no reset here.
    always_ff @(posedge i_Clk) begin
        if (wr_ok)
            mem[wr_idx] <= i_Wr_Data;
    end

    // Write index advance with wrap.
    always_ff @(posedge i_Clk or posedge i_Rst_Sync) begin
        if (i_Rst_Sync)
            wr_idx <= '0;
        else if (wr_ok)
            wr_idx <= IDX_W'(wrap_inc(32'(wr_idx), DEPTH));
    end

    // Read index advance and registered read data; data holds when idle.
    always_ff @(posedge i_Clk or posedge i_Rst_Sync) begin
        if (i_Rst_Sync) begin
            rd_idx    <= '0;
            o_Rd_Data <= '0;
        end else if (rd_ok) begin
            o_Rd_Data <= mem[rd_idx];
            rd_idx    <= IDX_W'(wrap_inc(32'(rd_idx), DEPTH));
        end
    end

    // Occupancy count: moves only when exactly one side is accepted.
    always_ff @(posedge i_Clk or posedge i_Rst_Sync) begin
        if (i_Rst_Sync)
            count <= '0;
        else begin
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_registers.sv
// Directed and randomized bench for fifo_registers, checked against a
// queue-based model of the FIFO.
module tb_fifo_registers;

    logic       r_Clock = 1'b0;
    logic       rst     = 1'b0;
    logic       wr_en   = 1'b0;
    logic       rd_en   = 1'b0;
    logic [7:0] wr_data = '0;
    logic       o_AF, o_Full, o_AE, o_Empty;
    logic [7:0] o_Rd_Data;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] m_rd = '0;

    always #5 r_Clock = ~r_Clock;

    fifo_registers #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(2), .AE_LEVEL(2)) dut (
        .i_Clk      (r_Clock),
        .i_Rst_Sync (rst),
        .i_Wr_En    (wr_en),
        .i_Wr_Data  (wr_data),
        .o_AF       (o_AF),
        .o_Full     (o_Full),
        .i_Rd_En    (rd_en),
        .o_Rd_Data  (o_Rd_Data),
        .o_AE       (o_AE),
        .o_Empty    (o_Empty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model's occupancy and last read.
    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, "_empty"}, 32'(o_Empty), 32'(n == 0));
        check({tag, "_full"},  32'(o_Full),  32'(n == 4));
        check({tag, "_af"},    32'(o_AF),    32'(n >= 2));
        check({tag, "_ae"},    32'(o_AE),    32'(n <= 2));
        check({tag, "_rd"},    32'(o_Rd_Data), 32'(m_rd));
    endtask

    // One clock with the given requests; model follows the FIFO rules.
    task automatic step(input bit wr, input bit rd, input logic [7:0] d);
        bit was_full, was_empty;
        wr_en   = wr;
        rd_en   = rd;
        wr_data = d;
        @(posedge r_Clock);
        was_full  = (q.size() == 4);
        was_empty = (q.size() == 0);
        if (rd && !was_empty) m_rd = q.pop_front();
        if (wr && !was_full)  q.push_back(d);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Assert reset between edges and check the flags react without a clock.
    task automatic do_reset(input string tag);
        #3;
        rst = 1'b1;
        q.delete();
        m_rd = '0;
        #1;
        check_all({tag, "_async"});
        @(posedge r_Clock);
        #1;
        rst = 1'b0;
        check_all({tag, "_held"});
    endtask

    initial begin
        // 1: reset, including a mid-cycle asynchronous assertion
        @(posedge r_Clock);
        #1;
        do_reset("rst0");

        // 2: fill to full, then an ignored write
        step(1, 0, 8'h11); check_all("wr1"); check("wr1_af", 32'(o_AF), 0);
        step(1, 0, 8'h22); check_all("wr2"); check("wr2_af", 32'(o_AF), 1);
        check("wr2_ae", 32'(o_AE), 1);
        step(1, 0, 8'h33); check_all("wr3"); check("wr3_ae", 32'(o_AE), 0);
        step(1, 0, 8'h44); check_all("wr4"); check("wr4_full", 32'(o_Full), 1);
        step(1, 0, 8'h55); check_all("wr5_ignored");

        // 3: drain, then an ignored read keeps the last data
        step(0, 1, 8'h00); check_all("rd1"); check("rd1_data", 32'(o_Rd_Data), 32'h11);
        step(0, 1, 8'h00); check_all("rd2"); check("rd2_data", 32'(o_Rd_Data), 32'h22);
        step(0, 1, 8'h00); check_all("rd3"); check("rd3_data", 32'(o_Rd_Data), 32'h33);
        step(0, 1, 8'h00); check_all("rd4"); check("rd4_data", 32'(o_Rd_Data), 32'h44);
        check("rd4_empty", 32'(o_Empty), 1);
        step(0, 1, 8'h00); check_all("rd5"); check("rd5_hold", 32'(o_Rd_Data), 32'h44);

        // 4: steady-state streaming across index wrap
        step(1, 0, 8'h60); check_all("pre1");
        step(1, 0, 8'h61); check_all("pre2");
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 8'(8'h62 + i));
            check_all("stream");
            check("stream_data", 32'(o_Rd_Data), 32'(8'h60 + i));
        end

        // 5: simultaneous wr+rd at empty and at full
        do_reset("rst1");
        step(1, 1, 8'h77); check_all("both_empty");
        check("both_empty_rd", 32'(o_Rd_Data), 0);
        step(1, 0, 8'h78); step(1, 0, 8'h79); step(1, 0, 8'h7A);
        check_all("refill");
        step(1, 1, 8'h7B); check_all("both_full");
        check("both_full_rd", 32'(o_Rd_Data), 32'h77);
        check("both_full_notfull", 32'(o_Full), 0);

        // 6: reset with data stored discards it
        do_reset("rst2");
        step(1, 0, 8'h01); step(1, 0, 8'h02); step(1, 0, 8'h03);
        check_all("three");
        do_reset("rst3");
        step(1, 0, 8'hA5); check_all("post_rst_wr");
        step(0, 1, 8'h00); check_all("post_rst_rd");
        check("post_rst_data", 32'(o_Rd_Data), 32'hA5);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0)
                do_reset("rnd_rst");
            else begin
                step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                     8'($urandom));
                check_all("rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
